madgwick_wb_ctrl: RTL and testbench
===================================

# madgwick_wb_ctrl

Parametrised Wishbone front-end for the Madgwick attitude filter core in the attitude_sensor peripheral. It stages accelerometer and gyro samples written by the SweRVolf CPU into a sample FIFO, sequences them into the filter core over a valid/ready handshake, and latches the resulting quaternion. Software can run one update per start request or drain the FIFO back-to-back in continuous mode.

## Interface
Parameters:
- ACC_WIDTH, 11: accelerometer sample width, signed.
- GYRO_WIDTH, 14: gyro sample width, signed.
- Q_WIDTH, 32: quaternion component width.
- FIFO_DEPTH, 4: sample FIFO entries, power of two, ≥2.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- adr_i  in  6  Wishbone byte address.
- dat_i  in  32  Wishbone write data.
- dat_o  out  32  Wishbone read data.
- we_i, stb_i, cyc_i  in  1 each  Wishbone write enable, strobe, cycle.
- ack_o  out  1  Wishbone acknowledge.
- rst_n_madgwick  out  1  core reset, active low.
- valid_in_madgwick  out  1  sample valid to core.
- ready_in_madgwick  in  1  core accepts sample.
- a_x_o, a_y_o, a_z_o  out  ACC_WIDTH each  FIFO-head accel sample.
- w_x_o, w_y_o, w_z_o  out  GYRO_WIDTH each  FIFO-head gyro sample.
- valid_out_madgwick  in  1  core result valid.
- ready_out_madgwick  out  1  controller accepts result.
- q_w_i, q_x_i, q_y_i, q_z_i  in  Q_WIDTH each  core quaternion.
- irq_o  out  1  done interrupt (MADGWICK_IRQ_EN only).

## Operation
- Register map: 0x00 CTRL; 0x04–0x0C a_x/a_y/a_z staging; 0x10–0x18 w_x/w_y/w_z staging; 0x1C–0x28 q_w/q_x/q_y/q_z (RO); 0x2C STATUS (RO). Other addresses: read 0, writes ignored, still acked.
- CTRL bits: [0] enable, [1] start, [2] done (RO), [3] continuous, [4] fifo_full (RO), [5] fifo_empty (RO), [6] overflow (sticky, write 1 clears), [7] irq_en. Staging registers keep the low ACC_WIDTH/GYRO_WIDTH bits of dat_i; a read returns the value sign-extended to 32 bits.
- Writing 0x18 (w_z) commits all six staging values as one FIFO entry. If the FIFO is full, the commit is dropped and overflow is set.
- STATUS: [3:0] FIFO count, [15:8] completed-update counter (wraps at 255, cleared by reset or disable).
- rst_n_madgwick = enable. Clearing enable flushes the FIFO, moves the FSM to IDLE and clears done; staging and quaternion registers are kept.
- FSM states and transitions:
  - IDLE → LOAD when enable, FIFO not empty, and either a start rising edge or continuous=1.
  - LOAD: valid_in high, outputs show the FIFO head. When ready_in is seen, pop the head and go to WAIT.
  - WAIT: ready_out high. When valid_out is seen, latch q_*, increment the counter and go to DONE.
  - DONE: done=1. Single mode returns to IDLE when start is cleared. Continuous mode goes to LOAD next cycle if the FIFO is not empty, otherwise to IDLE with done still 1.
- A start edge with an empty FIFO is ignored. Commit and pop in the same cycle are both performed, so the count is unchanged; a commit when full is accepted only if a pop happens in that cycle.

## Timing
- ack_o is registered: high the cycle after stb_i&cyc_i and the cycle before it is cleared, one cycle wide, low for at least one cycle between transfers. dat_o is valid while ack_o is high. Writes take effect on the ack edge.
- Latency: the start write ack edge to valid_in high is 2 cycles. valid_out accepted to done readable is 1 cycle.
- Reset: every register, FIFO pointer and counter is 0. Reset values of outputs: ack_o=0, dat_o=0, rst_n_madgwick=0, valid_in=0, ready_out=0, irq_o=0, sample outputs 0. Reset mid-transfer aborts the transfer and any core operation at once.

## Configuration
- MADGWICK_IRQ_EN defined: irq_o is a level set on entry to DONE when irq_en=1, and cleared by a write-1 to CTRL[2] or by disable.
- Without it: irq_o is tied to 0, CTRL[7] reads 0 and ignores writes.

## Test plan
- Reset, then read 0x00 → 0x20 (empty); ack_o is one cycle wide.
- Enable, write a_x=0x7B8, a_y=0x14A, a_z=0x0C4, w_x=0x3F1F, w_y=0x05C, w_z=0x3F54, then start; core model returns q_w=0x40000000 → done=1, 0x1C reads 0x40000000, STATUS[15:8]=1, and a_x_o=0x7B8 was presented.
- Commit FIFO_DEPTH+1 samples without start → fifo_full=1, overflow=1, count=4. Write 0x40 to CTRL → overflow cleared.
- Continuous mode with 3 queued samples and ready_in stalled 5 cycles per sample → 3 results, counter=3, FIFO empty, done=1.
- Clear enable while in WAIT → rst_n_madgwick low next cycle, FIFO count 0, done 0, valid_out ignored.
- With MADGWICK_IRQ_EN and irq_en=1 → irq_o rises one cycle after the result; writing 0x04 to CTRL clears it.

Source files
------------

// File: rtl/madgwick_wb_ctrl.sv
// Wishbone front-end for the Madgwick filter core: staging registers, sample FIFO, core sequencer.
// Optional feature: define MADGWICK_IRQ_EN to enable the done interrupt (irq_o, CTRL[7]).
module madgwick_wb_ctrl #(
  parameter int ACC_WIDTH  = 11,
  parameter int GYRO_WIDTH = 14,
  parameter int Q_WIDTH    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            adr_i,
  input  logic [31:0]           dat_i,
  output logic [31:0]           dat_o,
  input  logic                  we_i,
  input  logic                  stb_i,
  input  logic                  cyc_i,
  output logic                  ack_o,
  output logic                  rst_n_madgwick,
  output logic                  valid_in_madgwick,
  input  logic                  ready_in_madgwick,
  output logic [ACC_WIDTH-1:0]  a_x_o,
  output logic [ACC_WIDTH-1:0]  a_y_o,
  output logic [ACC_WIDTH-1:0]  a_z_o,
  output logic [GYRO_WIDTH-1:0] w_x_o,
  output logic [GYRO_WIDTH-1:0] w_y_o,
  output logic [GYRO_WIDTH-1:0] w_z_o,
  input  logic                  valid_out_madgwick,
  output logic                  ready_out_madgwick,
  input  logic [Q_WIDTH-1:0]    q_w_i,
  input  logic [Q_WIDTH-1:0]    q_x_i,
  input  logic [Q_WIDTH-1:0]    q_y_i,
  input  logic [Q_WIDTH-1:0]    q_z_i,
  output logic                  irq_o
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int A  = ACC_WIDTH;
  localparam int G  = GYRO_WIDTH;
  localparam int EW = 3*A + 3*G;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  logic          r_ack;
  logic [31:0]   r_dat_o;
  logic          r_enable, r_start, r_cont, r_ovf, r_done;
  logic          r_start_d, r_start_rise;
  logic [A-1:0]  r_ax, r_ay, r_az, r_sax, r_say, r_saz;
  logic [G-1:0]  r_wx, r_wy, r_wz, r_swx, r_swy, r_swz;
  logic [Q_WIDTH-1:0] r_qw, r_qx, r_qy, r_qz;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_count;
  logic [7:0]    r_upd;
  state_t        r_state;
  logic          r_valid_in, r_ready_out;

  logic          w_acc, w_wr, w_ctrl_wr, w_dis, w_run, w_commit;
  logic          w_full, w_empty, w_pop, w_push, w_q_acc, w_enter_load;
  logic [3:0]    w_word;
  logic [EW-1:0] w_entry, w_head;
  logic [31:0]   w_rdata;
  logic          w_irq_en_rd;
  logic          w_unused_bits;

  assign w_acc     = stb_i & cyc_i & ~r_ack;
  assign w_wr      = w_acc & we_i;
  assign w_word    = adr_i[5:2];
  assign w_ctrl_wr = w_wr && (w_word == 4'd0);
  // Any CTRL write with enable=0 flushes in the same edge, so the core side never sees a stale handshake.
  assign w_dis     = w_ctrl_wr && !dat_i[0];
  assign w_run     = r_enable && !w_dis;
  assign w_commit  = w_wr && (w_word == 4'd6);
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_pop     = w_run && (r_state == S_LOAD) && ready_in_madgwick;
  assign w_push    = w_commit && (!w_full || w_pop);
  assign w_q_acc   = w_run && (r_state == S_WAIT) && valid_out_madgwick;
  assign w_entry   = {dat_i[G-1:0], r_wy, r_wx, r_az, r_ay, r_ax};
  assign w_head    = r_mem[r_rp];
  assign w_enter_load = w_run && !w_empty &&
                        (((r_state == S_IDLE) && (r_start_rise || r_cont)) ||
                         ((r_state == S_DONE) && r_cont));
  assign w_unused_bits = ^{dat_i, adr_i[1:0]};

  assign ack_o              = r_ack;
  assign dat_o              = r_dat_o;
  assign rst_n_madgwick     = r_enable;
  assign valid_in_madgwick  = r_valid_in;
  assign ready_out_madgwick = r_ready_out;
  assign a_x_o = r_sax;
  assign a_y_o = r_say;
  assign a_z_o = r_saz;
  assign w_x_o = r_swx;
  assign w_y_o = r_swy;
  assign w_z_o = r_swz;

  always_comb begin
    w_rdata = 32'd0;
    case (w_word)
      4'd0:  w_rdata = {24'd0, w_irq_en_rd, r_ovf, w_empty, w_full, r_cont, r_done, r_start, r_enable};
      4'd1:  w_rdata = 32'($signed(r_ax));
      4'd2:  w_rdata = 32'($signed(r_ay));
      4'd3:  w_rdata = 32'($signed(r_az));
      4'd4:  w_rdata = 32'($signed(r_wx));
      4'd5:  w_rdata = 32'($signed(r_wy));
      4'd6:  w_rdata = 32'($signed(r_wz));
      4'd7:  w_rdata = 32'(r_qw);
      4'd8:  w_rdata = 32'(r_qx);
      4'd9:  w_rdata = 32'(r_qy);
      4'd10: w_rdata = 32'(r_qz);
      4'd11: w_rdata = {16'd0, r_upd, 4'd0, 4'(r_count)};
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack <= 1'b0; r_dat_o <= '0;
      r_enable <= 1'b0; r_start <= 1'b0; r_cont <= 1'b0; r_ovf <= 1'b0;
      r_ax <= '0; r_ay <= '0; r_az <= '0; r_wx <= '0; r_wy <= '0; r_wz <= '0;
    end else begin
      r_ack   <= w_acc;
      r_dat_o <= w_acc ? w_rdata : 32'd0;
      if (w_wr) begin
        case (w_word)
          4'd0: begin
            r_enable <= dat_i[0];
            r_start  <= dat_i[1];
            r_cont   <= dat_i[3];
            if (dat_i[6]) r_ovf <= 1'b0;
          end
          4'd1: r_ax <= dat_i[A-1:0];
          4'd2: r_ay <= dat_i[A-1:0];
          4'd3: r_az <= dat_i[A-1:0];
          4'd4: r_wx <= dat_i[G-1:0];
          4'd5: r_wy <= dat_i[G-1:0];
          4'd6: r_wz <= dat_i[G-1:0];
          default: ;
        endcase
      end
      if (w_commit && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0; r_rp <= '0; r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_dis) begin
      r_wp <= '0; r_rp <= '0; r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= w_entry;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Head is stable for the whole LOAD phase, so sampling it once on entry is enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sax <= '0; r_say <= '0; r_saz <= '0; r_swx <= '0; r_swy <= '0; r_swz <= '0;
    end else if (w_enter_load) begin
      r_sax <= w_head[0 +: A];
      r_say <= w_head[A +: A];
      r_saz <= w_head[2*A +: A];
      r_swx <= w_head[3*A +: G];
      r_swy <= w_head[3*A+G +: G];
      r_swz <= w_head[3*A+2*G +: G];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_qw <= '0; r_qx <= '0; r_qy <= '0; r_qz <= '0;
    end else if (w_q_acc) begin
      r_qw <= q_w_i; r_qx <= q_x_i; r_qy <= q_y_i; r_qz <= q_z_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE; r_valid_in <= 1'b0; r_ready_out <= 1'b0; r_done <= 1'b0;
      r_upd <= '0; r_start_d <= 1'b0; r_start_rise <= 1'b0;
    end else begin
      r_start_d    <= r_start;
      r_start_rise <= r_start & ~r_start_d;
      if (!w_run) begin
        r_state <= S_IDLE; r_valid_in <= 1'b0; r_ready_out <= 1'b0; r_done <= 1'b0;
        r_upd <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (w_enter_load) begin
            r_state <= S_LOAD; r_valid_in <= 1'b1; r_done <= 1'b0;
          end
          S_LOAD: if (ready_in_madgwick) begin
            r_state <= S_WAIT; r_valid_in <= 1'b0; r_ready_out <= 1'b1;
          end
          S_WAIT: if (valid_out_madgwick) begin
            r_state <= S_DONE; r_ready_out <= 1'b0; r_done <= 1'b1;
            r_upd <= r_upd + 8'd1;
          end
          S_DONE: begin
            if (w_enter_load) begin
              r_state <= S_LOAD; r_valid_in <= 1'b1; r_done <= 1'b0;
            end else if (r_cont) begin
              r_state <= S_IDLE;
            end else if (!r_start) begin
              r_state <= S_IDLE; r_done <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef MADGWICK_IRQ_EN
  logic r_irq_en, r_irq;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_en <= 1'b0; r_irq <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= dat_i[7];
      if (!w_run || (w_ctrl_wr && dat_i[2])) r_irq <= 1'b0;
      else if (w_q_acc && r_irq_en)          r_irq <= 1'b1;
    end
  end
  assign irq_o       = r_irq;
  assign w_irq_en_rd = r_irq_en;
`else
  assign irq_o       = 1'b0;
  assign w_irq_en_rd = 1'b0;
`endif
endmodule

// File: tb/tb_madgwick_wb_ctrl.sv
// Directed bench for madgwick_wb_ctrl with a queue-based FIFO/register model and a simple core model.
module tb_madgwick_wb_ctrl;
  localparam int DEPTH = 4;

  logic        clk, rst;
  logic [5:0]  adr_i;
  logic [31:0] dat_i, dat_o;
  logic        we_i, stb_i, cyc_i, ack_o;
  logic        rst_n_madgwick, valid_in_madgwick, ready_in_madgwick;
  logic [10:0] a_x_o, a_y_o, a_z_o;
  logic [13:0] w_x_o, w_y_o, w_z_o;
  logic        valid_out_madgwick, ready_out_madgwick, irq_o;
  logic [31:0] q_w_i, q_x_i, q_y_i, q_z_i;

  madgwick_wb_ctrl dut (
    .clk(clk), .rst(rst), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o),
    .rst_n_madgwick(rst_n_madgwick), .valid_in_madgwick(valid_in_madgwick),
    .ready_in_madgwick(ready_in_madgwick),
    .a_x_o(a_x_o), .a_y_o(a_y_o), .a_z_o(a_z_o),
    .w_x_o(w_x_o), .w_y_o(w_y_o), .w_z_o(w_z_o),
    .valid_out_madgwick(valid_out_madgwick), .ready_out_madgwick(ready_out_madgwick),
    .q_w_i(q_w_i), .q_x_i(q_x_i), .q_y_i(q_y_i), .q_z_i(q_z_i), .irq_o(irq_o)
  );

  typedef struct {
    logic [10:0] ax, ay, az;
    logic [13:0] wx, wy, wz;
  } samp_t;

  int n_tests = 0, n_fail = 0;
  int cyc_cnt = 0, acc_cyc = -1;
  // model state
  samp_t       m_q[$];
  samp_t       m_st;
  logic        m_en = 0, m_start = 0, m_cont = 0, m_ovf = 0, m_irq_en = 0;
  logic [7:0]  m_cnt = 0;
  logic [31:0] m_qw = 0, m_qz = 0;
  logic [10:0] last_ax = 0;
  // core model controls
  int   stall = 0, st_cnt = 0, n_res = 0;
  logic core_hold = 0, core_force = 0;
  logic [10:0] s_ax;
  logic [13:0] s_wx;

  initial begin clk = 0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_ctrl(input logic done);
    exp_ctrl = {24'd0, m_irq_en, m_ovf, m_q.size() == 0, m_q.size() == DEPTH,
                m_cont, done, m_start, m_en};
  endfunction

  function automatic logic [31:0] exp_status();
    exp_status = {16'd0, m_cnt, 4'd0, 4'(m_q.size())};
  endfunction

  task automatic model_write(input logic [5:0] a, input logic [31:0] d);
    case (a)
      6'h00: begin
        m_en = d[0]; m_start = d[1]; m_cont = d[3];
        if (d[6]) m_ovf = 0;
`ifdef MADGWICK_IRQ_EN
        m_irq_en = d[7];
`endif
        if (!d[0]) begin m_q.delete(); m_cnt = 0; end
      end
      6'h04: m_st.ax = d[10:0];
      6'h08: m_st.ay = d[10:0];
      6'h0C: m_st.az = d[10:0];
      6'h10: m_st.wx = d[13:0];
      6'h14: m_st.wy = d[13:0];
      6'h18: begin
        m_st.wz = d[13:0];
        if (m_q.size() < DEPTH) m_q.push_back(m_st);
        else m_ovf = 1;
      end
      default: ;
    endcase
  endtask

  task automatic wb_xfer(input logic [5:0] a, input logic w, input logic [31:0] d,
                         output logic [31:0] rd);
    int n;
    adr_i = a; we_i = w; dat_i = d; stb_i = 1; cyc_i = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack_o && n < 10);
    check("wb_ack_seen", {31'd0, ack_o}, 32'd1);
    rd = dat_o;
    stb_i = 0; cyc_i = 0; we_i = 0;
    if (ack_o && w) model_write(a, d);
    @(posedge clk); #1;
    check("wb_ack_one_cycle", {31'd0, ack_o}, 32'd0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    logic [31:0] rd;
    wb_xfer(a, 1'b1, d, rd);
  endtask

  task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(a, 1'b0, 32'd0, rd);
    check(name, rd, exp);
  endtask

  // Core model: raises ready_in after `stall` cycles of valid_in, answers each WAIT with a result.
  initial begin
    ready_in_madgwick = 0; valid_out_madgwick = 0;
    q_w_i = 0; q_x_i = 0; q_y_i = 0; q_z_i = 0; s_ax = 0; s_wx = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        ready_in_madgwick = 0; valid_out_madgwick = 0;
      end else begin
        if (ready_in_madgwick) ready_in_madgwick = 0;
        else if (valid_in_madgwick) begin
          if (st_cnt >= stall) begin
            ready_in_madgwick = 1; s_ax = a_x_o; s_wx = w_x_o; st_cnt = 0;
          end else st_cnt++;
        end
        if (core_hold) begin
          valid_out_madgwick = core_force;
          if (core_force) q_w_i = 32'hDEAD_BEEF;
        end else if (valid_out_madgwick) begin
          if (!ready_out_madgwick) begin valid_out_madgwick = 0; n_res++; end
        end else if (ready_out_madgwick) begin
          valid_out_madgwick = 1;
          q_w_i = 32'h4000_0000 + 32'(n_res);
          q_x_i = {21'd0, s_ax};
          q_y_i = {18'd0, s_wx};
          q_z_i = ~32'(n_res);
        end
      end
    end
  end

  // Per-cycle checks of the core-facing side against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_n_core", {31'd0, rst_n_madgwick}, {31'd0, m_en});
      check("vin_rout_excl", {31'd0, valid_in_madgwick & ready_out_madgwick}, 32'd0);
      if (valid_in_madgwick) begin
        if (m_q.size() == 0) check("head_exists", 32'd0, 32'd1);
        else begin
          check("a_x_o", {21'd0, a_x_o}, {21'd0, m_q[0].ax});
          check("a_y_o", {21'd0, a_y_o}, {21'd0, m_q[0].ay});
          check("a_z_o", {21'd0, a_z_o}, {21'd0, m_q[0].az});
          check("w_x_o", {18'd0, w_x_o}, {18'd0, m_q[0].wx});
          check("w_y_o", {18'd0, w_y_o}, {18'd0, m_q[0].wy});
          check("w_z_o", {18'd0, w_z_o}, {18'd0, m_q[0].wz});
          if (ready_in_madgwick) begin last_ax = a_x_o; void'(m_q.pop_front()); end
        end
      end
      if (valid_out_madgwick && ready_out_madgwick) begin
        m_cnt++; m_qw = q_w_i; m_qz = q_z_i; acc_cyc = cyc_cnt;
      end
    end
  end

  initial begin
    int base, n;
    rst = 1; adr_i = 0; dat_i = 0; we_i = 0; stb_i = 0; cyc_i = 0;
    m_st = '{default: '0};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    // reset state
    check("rst_ack", {31'd0, ack_o}, 32'd0);
    check("rst_dat_o", dat_o, 32'd0);
    check("rst_core_n", {31'd0, rst_n_madgwick}, 32'd0);
    check("rst_vin", {31'd0, valid_in_madgwick}, 32'd0);
    check("rst_rout", {31'd0, ready_out_madgwick}, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    check("rst_samples", {a_x_o, w_z_o}, 32'd0);
    rd_chk("rst_ctrl_lit", 6'h00, 32'h20);
    rd_chk("rst_ctrl_mdl", 6'h00, exp_ctrl(0));
    wr(6'h30, 32'hFFFF_FFFF);
    rd_chk("unmapped", 6'h30, 32'd0);
    rd_chk("rst_status", 6'h2C, 32'd0);

    // single update
    wr(6'h00, 32'h1);
    wr(6'h04, 32'h7B8); wr(6'h08, 32'h14A); wr(6'h0C, 32'h0C4);
    wr(6'h10, 32'h3F1F); wr(6'h14, 32'h05C); wr(6'h18, 32'h3F54);
    rd_chk("ax_sext", 6'h04, 32'hFFFF_FFB8);
    rd_chk("wx_sext", 6'h10, 32'hFFFF_FF1F);
    rd_chk("wy_pos", 6'h14, 32'h0000_005C);
    rd_chk("status_1", 6'h2C, 32'h1);
    wr(6'h00, 32'h3);
    check("lat_vin_early", {31'd0, valid_in_madgwick}, 32'd0);
    @(posedge clk); #1;
    check("lat_vin_2cyc", {31'd0, valid_in_madgwick}, 32'd1);
    n = 0;
    while (n_res < 1 && n < 50) begin @(posedge clk); #1; n++; end
    check("single_result", n_res, 1);
    rd_chk("single_ctrl_lit", 6'h00, 32'h27);
    rd_chk("single_ctrl_mdl", 6'h00, exp_ctrl(1));
    rd_chk("single_qw_lit", 6'h1C, 32'h4000_0000);
    rd_chk("single_qw_mdl", 6'h1C, m_qw);
    rd_chk("single_status", 6'h2C, 32'h0100);
    check("single_ax_presented", {21'd0, last_ax}, 32'h7B8);
    wr(6'h00, 32'h1);

    // overflow
    for (int i = 0; i < DEPTH + 1; i++) wr(6'h18, 32'h100 + 32'(i));
    rd_chk("ovf_ctrl_lit", 6'h00, 32'h51);
    rd_chk("ovf_ctrl_mdl", 6'h00, exp_ctrl(0));
    rd_chk("ovf_status", 6'h2C, 32'h0104);
    wr(6'h00, 32'h40);
    rd_chk("ovf_clear_lit", 6'h00, 32'h20);
    rd_chk("ovf_clear_mdl", 6'h00, exp_ctrl(0));

    // continuous mode, 3 samples, 5-cycle stall
    wr(6'h00, 32'h1);
    for (int i = 0; i < 3; i++) begin
      wr(6'h04, 32'h010 + 32'(i * 3));
      wr(6'h10, 32'h2000 + 32'(i));
      wr(6'h18, 32'h0A0 + 32'(i));
    end
    rd_chk("cont_status_q", 6'h2C, exp_status());
    stall = 5; base = n_res;
    wr(6'h00, 32'h9);
    n = 0;
    while (n_res < base + 3 && n < 300) begin @(posedge clk); #1; n++; end
    check("cont_results", n_res - base, 3);
    repeat (2) @(posedge clk); #1;
    rd_chk("cont_status_lit", 6'h2C, 32'h0300);
    rd_chk("cont_status_mdl", 6'h2C, exp_status());
    rd_chk("cont_ctrl_lit", 6'h00, 32'h2D);
    rd_chk("cont_ctrl_mdl", 6'h00, exp_ctrl(1));
    rd_chk("cont_qw_lit", 6'h1C, 32'h4000_0003);
    rd_chk("cont_qz_mdl", 6'h28, m_qz);
    stall = 0;

    // disable while in WAIT
    wr(6'h00, 32'h1);
    wr(6'h18, 32'h0055);
    core_hold = 1;
    wr(6'h00, 32'h3);
    n = 0;
    while (!ready_out_madgwick && n < 30) begin @(posedge clk); #1; n++; end
    check("dis_reached_wait", {31'd0, ready_out_madgwick}, 32'd1);
    wr(6'h00, 32'h0);
    check("dis_core_rst", {31'd0, rst_n_madgwick}, 32'd0);
    check("dis_rout", {31'd0, ready_out_madgwick}, 32'd0);
    core_force = 1;
    repeat (4) @(posedge clk); #1;
    core_force = 0;
    @(posedge clk); #1;
    core_hold = 0;
    rd_chk("dis_qw_kept", 6'h1C, 32'h4000_0003);
    rd_chk("dis_status", 6'h2C, 32'h0);
    rd_chk("dis_ctrl", 6'h00, 32'h20);

`ifdef MADGWICK_IRQ_EN
    wr(6'h00, 32'h81);
    wr(6'h18, 32'h0077);
    acc_cyc = -1;
    wr(6'h00, 32'h83);
    n = 0;
    while (!irq_o && n < 40) begin @(posedge clk); #1; n++; end
    check("irq_set", {31'd0, irq_o}, 32'd1);
    check("irq_timing", cyc_cnt, acc_cyc + 1);
    wr(6'h00, 32'h04);
    check("irq_cleared", {31'd0, irq_o}, 32'd0);
`else
    wr(6'h00, 32'h81);
    rd_chk("irq_en_ro0", 6'h00, 32'h21);
    wr(6'h18, 32'h0077);
    wr(6'h00, 32'h83);
    repeat (10) @(posedge clk); #1;
    check("irq_tied0", {31'd0, irq_o}, 32'd0);
    rd_chk("noirq_status", 6'h2C, 32'h0100);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
